int_to_float_conv: RTL and testbench
====================================

Name: int_to_float_conv

Overview:
- Multicycle integer-to-IEEE-754 single-precision converter; parametrised successor to the fixed 32-bit unsigned converter.
- Adds a configurable input width, a per-transaction signed/unsigned mode, round-to-nearest-even rounding and an inexact flag.
- Adds full strobe/ack handshakes on both input and output.
- Sits beside the FPU in the execute stage and services FCVT.S.W / FCVT.S.WU.

Parameters:
- INT_W, 32, input integer width; legal range 8..64.
- LZ_W, $clog2(INT_W), width of the internal shift counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- input_a  in  INT_W  integer operand.
- input_signed  in  1  1 = two's-complement operand, 0 = unsigned; sampled with input_a.
- input_a_stb  in  1  operand valid.
- input_a_ack  out  1  converter ready; transfer occurs on an edge where stb and ack are both 1.
- output_z  out  32  fp32 result.
- output_nx  out  1  inexact flag; 1 when rounding discarded non-zero bits.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accepts the result.

Behaviour:
- Reset: state=IDLE, input_a_ack=0, output_z=0, output_nx=0, output_z_stb=0. The first cycle after reset is IDLE with ack=1.
- Reset mid-operation abandons the current conversion. No output strobe is produced for it.
- FSM states: IDLE, UNPACK, NORMALISE, ROUND, OUTPUT.
- IDLE: ack=1. On stb&&ack, latch input_a and input_signed, drop ack, go to UNPACK.
- UNPACK:
  - sign = input_signed & a[INT_W-1].
  - mag = sign ? -a : a, held as INT_W-bit unsigned. Most-negative signed value gives mag=2^(INT_W-1).
  - exp = 127+INT_W-1.
  - If mag==0: output_z=0x00000000, nx=0, go to OUTPUT. Otherwise go to NORMALISE.
- NORMALISE:
  - If mag[INT_W-1]==1, go to ROUND.
  - Otherwise mag<<=1, exp-=1, stay in NORMALISE.
  - One shift per cycle, so lz+1 cycles in this state, where lz is the leading-zero count of mag.
- ROUND:
  - Mantissa m = mag[INT_W-2 -: 23]; zero-padded on the right when INT_W<24.
  - guard = next bit below m; sticky = OR of all remaining lower bits.
  - Round-to-nearest-even: increment when guard & (sticky | m[0]).
  - If the increment carries out of m, then m=0 and exp+=1.
  - nx = guard|sticky. For INT_W<=24, nx is always 0.
  - Register output_z = {sign, exp[7:0], m}. Go to OUTPUT.
- Overflow: exp ≤ 127+64, so overflow to infinity cannot occur.
- OUTPUT:
  - output_z_stb=1. output_z and output_nx are held stable until output_z_stb&&output_z_ack.
  - After the handshake: stb=0, go to IDLE; input_a_ack rises the cycle after.
- Latency, measured from the input accept edge to the edge that raises output_z_stb:
  - Non-zero operand: lz+3 edges.
  - Zero operand: 2 edges.
- Throughput: one operation in flight. No back-to-back acceptance while in OUTPUT.
- input_a changes while ack=0 are ignored.

Optional Feature:
- Macro INT2FP_RM_EN.
- When defined:
  - Adds input port input_rm[2:0], latched with input_a.
  - Supported modes: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
  - Increment rule: RTZ never increments. RDN increments when sign & (guard|sticky). RUP increments when !sign & (guard|sticky). RMM increments when guard.
  - Codes 101..111 behave as RNE.
- When undefined: the port is absent and rounding is fixed RNE.
- output_nx behaves identically with or without the macro.

Decomposition:
- Package int2fp_pkg holds:
  - state enum typedef int2fp_state_t;
  - constants FP32_BIAS=127, FP32_MAN_W=23, FP32_EXP_W=8;
  - rounding-mode localparams RM_RNE..RM_RMM.
- One natural sub-module, int2fp_round: combinational; takes m, guard, sticky, sign, rm; returns the rounded mantissa, a carry-out bit and nx. It is instantiated in the ROUND state path.

Test Plan:
- Unsigned, INT_W=32, a=0x00000002 -> output_z=0x40000000, nx=0, stb exactly 33 edges after accept.
- Unsigned a=0xFFF00000 -> 0x4F7FF000, nx=0. Signed a=0xFFFFFFFF -> 0xBF800000. Signed a=0x80000000 -> 0xCF000000 after 3 edges.
- Rounding: unsigned 0xFFFFFFFF -> 0x4F800000, nx=1 (mantissa carry). 0x01000001 -> 0x4B800000, nx=1 (tie to even). 0x01000003 -> 0x4B800002, nx=1.
- Zero: a=0, signed and unsigned -> 0x00000000, nx=0, stb 2 edges after accept.
- Backpressure: hold output_z_ack=0 for 5 cycles -> output_z, nx and stb stable throughout, input_a_ack=0; on ack, stb falls next edge and input_a_ack rises the edge after.
- Reset mid-NORMALISE for a=0x00000001 -> next edge all outputs 0, no stb; a fresh conversion of 0x00000003 then yields 0x40400000.

Source files
------------

// File: rtl/int2fp_pkg.sv
// rtl/int2fp_pkg.sv - shared types and constants for the integer-to-fp32 converter
package int2fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_NORMALISE,
        ST_ROUND,
        ST_OUTPUT
    } int2fp_state_t;

    localparam int FP32_BIAS  = 127;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_EXP_W = 8;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

endpackage

// File: rtl/int2fp_round.sv
// rtl/int2fp_round.sv - combinational mantissa rounding with carry-out and inexact flag
module int2fp_round
    import int2fp_pkg::*;
(
    input  logic [FP32_MAN_W-1:0] m,
    input  logic                  guard,
    input  logic                  sticky,
    input  logic                  sign,
    input  logic [2:0]            rm,
    output logic [FP32_MAN_W-1:0] m_rounded,
    output logic                  carry,
    output logic                  nx
);

    logic inc;

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | m[0]);
        endcase
    end

    // A carry out means the mantissa wrapped to zero and the exponent must bump.
    assign {carry, m_rounded} = {1'b0, m} + {{FP32_MAN_W{1'b0}}, inc};
    assign nx = guard | sticky;

endmodule

// File: rtl/int_to_float_conv.sv
// rtl/int_to_float_conv.sv - multicycle int-to-fp32 converter; INT2FP_RM_EN adds input_rm
module int_to_float_conv
    import int2fp_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int LZ_W  = $clog2(INT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] input_a,
    input  logic             input_signed,
`ifdef INT2FP_RM_EN
    input  logic [2:0]       input_rm,
`endif
    input  logic             input_a_stb,
    output logic             input_a_ack,
    output logic [31:0]      output_z,
    output logic             output_nx,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    localparam int EXT_W = INT_W + FP32_MAN_W + 1;
    localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(FP32_BIAS + INT_W - 1);

    int2fp_state_t state, next_state;

    logic [INT_W-1:0]      a_reg;
    logic                  signed_reg;
    logic                  sign;
    logic [INT_W-1:0]      mag;
    logic [LZ_W-1:0]       shift_cnt;
    logic                  unpack_sign;
    logic [INT_W-1:0]      unpack_mag;
    logic [EXT_W-1:0]      ext;
    logic [FP32_MAN_W-1:0] m_rounded;
    logic                  carry;
    logic                  round_nx;
    logic [2:0]            rm_sel;
    logic [FP32_EXP_W-1:0] exp_final;
    logic                  accept;

`ifdef INT2FP_RM_EN
    logic [2:0] rm_reg;
    assign rm_sel = rm_reg;
`else
    assign rm_sel = RM_RNE;
`endif

    assign accept      = input_a_stb & input_a_ack;
    assign unpack_sign = signed_reg & a_reg[INT_W-1];
    assign unpack_mag  = unpack_sign ? (~a_reg + 1'b1) : a_reg;

    // Right-padding lets one set of slices cover INT_W both below and above 24.
    assign ext = {mag, {(FP32_MAN_W + 1){1'b0}}};

    // The exponent is derived from the shift count rather than decremented per cycle.
    assign exp_final = EXP_TOP - FP32_EXP_W'(shift_cnt) + FP32_EXP_W'(carry);

    int2fp_round u_round (
        .m         (ext[EXT_W-2 -: FP32_MAN_W]),
        .guard     (ext[INT_W-1]),
        .sticky    (|ext[INT_W-2:0]),
        .sign      (sign),
        .rm        (rm_sel),
        .m_rounded (m_rounded),
        .carry     (carry),
        .nx        (round_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (accept) next_state = ST_UNPACK;
            ST_UNPACK:    next_state = (unpack_mag == '0) ? ST_OUTPUT : ST_NORMALISE;
            ST_NORMALISE: if (mag[INT_W-1]) next_state = ST_ROUND;
            ST_ROUND:     next_state = ST_OUTPUT;
            ST_OUTPUT:    if (output_z_stb && output_z_ack) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_a_ack  <= 1'b0;
            output_z     <= '0;
            output_nx    <= 1'b0;
            output_z_stb <= 1'b0;
            a_reg        <= '0;
            signed_reg   <= 1'b0;
            sign         <= 1'b0;
            mag          <= '0;
            shift_cnt    <= '0;
`ifdef INT2FP_RM_EN
            rm_reg       <= RM_RNE;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg       <= input_a;
                        signed_reg  <= input_signed;
`ifdef INT2FP_RM_EN
                        rm_reg      <= input_rm;
`endif
                        input_a_ack <= 1'b0;
                    end else begin
                        input_a_ack <= 1'b1;
                    end
                end
                ST_UNPACK: begin
                    sign      <= unpack_sign;
                    mag       <= unpack_mag;
                    shift_cnt <= '0;
                    if (unpack_mag == '0) begin
                        output_z  <= '0;
                        output_nx <= 1'b0;
                    end
                end
                ST_NORMALISE: begin
                    if (!mag[INT_W-1]) begin
                        mag       <= mag << 1;
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ST_ROUND: begin
                    output_z     <= {sign, exp_final, m_rounded};
                    output_nx    <= round_nx;
                    output_z_stb <= 1'b1;
                end
                ST_OUTPUT: begin
                    // The zero path enters here without the strobe and raises it one edge later.
                    if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
                    else                              output_z_stb <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_conv.sv
// tb/tb_int_to_float_conv.sv - scoreboard bench for int_to_float_conv with directed vectors
module tb_int_to_float_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = '0;
    logic        input_signed = 1'b0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_nx;
    logic        output_z_stb;
    logic        output_z_ack = 1'b1;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [31:0] z;
        logic        nx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int_to_float_conv #(.INT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_signed (input_signed),
`ifdef INT2FP_RM_EN
        .input_rm     (3'b000),
`endif
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_nx    (output_nx),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic sgn, input logic [31:0] z,
                         input logic nx, input int lat, input bit push);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(posedge clk); #2;
        input_a      = a;
        input_signed = sgn;
        input_a_stb  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (input_a_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.z = z; e.nx = nx; e.lat = lat; e.acc = int'(cyc) + 1;
            sb.push_back(e);
        end
        @(posedge clk); #2;
        input_a_stb  = 1'b0;
        input_a      = $urandom;
        input_signed = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && input_a_ack) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    bit          held = 1'b0;
    int          post = 0;
    logic [31:0] hz;
    logic        hnx;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
            post = 0;
        end else begin
            if (post == 1) begin
                chk("stb_fall", 32'(output_z_stb), 32'd0);
                chk("ack_low_after_hs", 32'(input_a_ack), 32'd0);
                post = 2;
            end else if (post == 2) begin
                chk("ack_rise", 32'(input_a_ack), 32'd1);
                post = 0;
            end
            if (output_z_stb) begin
                if (!held) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_stb", 32'd1, 32'd0);
                    end else begin
                        chk("z", output_z, sb[0].z);
                        chk("nx", 32'(output_nx), 32'(sb[0].nx));
                        chk("latency", 32'(int'(cyc) - sb[0].acc), 32'(sb[0].lat));
                    end
                    held = 1'b1;
                    hz   = output_z;
                    hnx  = output_nx;
                end else begin
                    chk("z_stable", output_z, hz);
                    chk("nx_stable", 32'(output_nx), 32'(hnx));
                    chk("ack_low_in_output", 32'(input_a_ack), 32'd0);
                end
                if (output_z_ack) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    held = 1'b0;
                    post = 1;
                end
            end
        end
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(input_a_ack), 32'd0);
        chk("rst_z", output_z, 32'd0);
        chk("rst_nx", 32'(output_nx), 32'd0);
        chk("rst_stb", 32'(output_z_stb), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        issue(32'h0000_0002, 1'b0, 32'h4000_0000, 1'b0, 33, 1'b1); wait_idle();
        issue(32'hFFF0_0000, 1'b0, 32'h4F7F_F000, 1'b0, 3,  1'b1); wait_idle();
        issue(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34, 1'b1); wait_idle();
        issue(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3,  1'b1); wait_idle();
        issue(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3,  1'b1); wait_idle();
        issue(32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10, 1'b1); wait_idle();
        issue(32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10, 1'b1); wait_idle();
        issue(32'h0100_0005, 1'b0, 32'h4B80_0002, 1'b1, 10, 1'b1); wait_idle();
        issue(32'h0200_0003, 1'b0, 32'h4C00_0001, 1'b1, 9,  1'b1); wait_idle();
        issue(32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 32, 1'b1); wait_idle();
        issue(32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 2,  1'b1); wait_idle();
        issue(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 2,  1'b1); wait_idle();

        // Backpressure: consumer withholds ack for 5 cycles.
        output_z_ack = 1'b0;
        issue(32'h0000_0100, 1'b0, 32'h4380_0000, 1'b0, 26, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (output_z_stb) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("bp_stb_timeout", 32'd0, 32'd1);
        repeat (5) @(posedge clk);
        #2 output_z_ack = 1'b1;
        wait_idle();

        // Reset mid-normalise abandons the conversion without a strobe.
        issue(32'h0000_0001, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_z", output_z, 32'd0);
        chk("midrst_nx", 32'(output_nx), 32'd0);
        chk("midrst_stb", 32'(output_z_stb), 32'd0);
        chk("midrst_ack", 32'(input_a_ack), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        issue(32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0, 33, 1'b1); wait_idle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
